// File: rtl/messbauer_channel_sequencer.sv
// Start/channel pulse sequencer feeding the velocity generator and spectrum accumulator.
// Optional: define MESSBAUER_CHANNEL_SEQUENCER_ABORT_EN to abort a sweep when enable drops.
module messbauer_channel_sequencer #(
   parameter int CHANNEL_NUMBER      = 512,
   parameter int CHANNEL_INDEX_WIDTH = 9,
   parameter int CHANNEL_PERIOD_CLK  = 100,
   parameter int PULSE_WIDTH_CLK     = 10,
   parameter int START_WIDTH_CLK     = 20,
   parameter int SWEEP_COUNT_WIDTH   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   output logic                           start,
   output logic                           channel,
   output logic [CHANNEL_INDEX_WIDTH-1:0] channel_index,
   output logic [SWEEP_COUNT_WIDTH-1:0]   sweep_count,
   output logic                           busy,
   output logic                           sweep_done
);

   localparam int CNT_MAX = (START_WIDTH_CLK > CHANNEL_PERIOD_CLK) ?
                            START_WIDTH_CLK : CHANNEL_PERIOD_CLK;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IW      = CHANNEL_INDEX_WIDTH;
   localparam int SW      = SWEEP_COUNT_WIDTH;

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_WIDTH_CLK - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CHANNEL_PERIOD_CLK - 1);
   localparam logic [CNT_W-1:0] PULSE_END  = CNT_W'(PULSE_WIDTH_CLK);
   localparam logic [IW-1:0]    IDX_LAST   = IW'(CHANNEL_NUMBER - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_RUN
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [SW-1:0]    sweep_count_q, sweep_count_d;
   logic             start_q, start_d;
   logic             channel_q, channel_d;
   logic             busy_q, busy_d;
   logic             sweep_done_q, sweep_done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         idx_q         <= '0;
         sweep_count_q <= '0;
         start_q       <= 1'b0;
         channel_q     <= 1'b0;
         busy_q        <= 1'b0;
         sweep_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         sweep_count_q <= sweep_count_d;
         start_q       <= start_d;
         channel_q     <= channel_d;
         busy_q        <= busy_d;
         sweep_done_q  <= sweep_done_d;
      end
   end

   // cnt_q counts START clocks in START and the slot position in RUN
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_START;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == START_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (cnt_q == SLOT_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = enable ? S_START : S_IDLE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
`ifdef MESSBAUER_CHANNEL_SEQUENCER_ABORT_EN
      if (state_q != S_IDLE && !enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end
`endif
   end

   // Outputs are decoded from the next state so they land in flops
   always_comb begin
      start_d       = (state_d == S_START);
      busy_d        = (state_d != S_IDLE);
      channel_d     = (state_d == S_RUN) && (cnt_d < PULSE_END);
      sweep_done_d  = (state_d == S_RUN) && (cnt_d == SLOT_LAST) &&
                      (idx_d == IDX_LAST);
      sweep_count_d = sweep_count_q + SW'(sweep_done_d);
   end

   assign start         = start_q;
   assign channel       = channel_q;
   assign channel_index = idx_q;
   assign sweep_count   = sweep_count_q;
   assign busy          = busy_q;
   assign sweep_done    = sweep_done_q;

endmodule

// File: doc/messbauer_channel_sequencer.md
Name: messbauer_channel_sequencer

Overview:
- Source side of the channel/start interface that drives the saw-tooth velocity generator and the spectrum accumulator.
- Produces a start pulse per sweep, then a train of CHANNEL_NUMBER channel pulses at a fixed clock-derived period.
- Sweep consumers act on the falling edge of channel, so each channel pulse's falling edge is the channel-advance event.
- Reports the current channel index and a completed-sweep counter.

Parameters:
- CHANNEL_NUMBER, 512, channels per sweep (>=2).
- CHANNEL_INDEX_WIDTH, 9, width of channel_index; 2**CHANNEL_INDEX_WIDTH >= CHANNEL_NUMBER.
- CHANNEL_PERIOD_CLK, 100, clocks per channel slot (>=2).
- PULSE_WIDTH_CLK, 10, clocks channel is high within a slot; 1 <= PULSE_WIDTH_CLK < CHANNEL_PERIOD_CLK.
- START_WIDTH_CLK, 20, clocks start is high at the head of each sweep (>=1).
- SWEEP_COUNT_WIDTH, 16, width of sweep_count.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  level request to run sweeps.
- start  output  1  high during the START phase of each sweep.
- channel  output  1  channel pulse; falling edge = channel advance.
- channel_index  output  CHANNEL_INDEX_WIDTH  index of the current slot.
- sweep_count  output  SWEEP_COUNT_WIDTH  completed sweeps; wraps modulo 2**SWEEP_COUNT_WIDTH.
- busy  output  1  high in any state other than IDLE.
- sweep_done  output  1  one-clock strobe on the last clock of each completed sweep.

Behaviour:
- All outputs registered. On rst: every output = 0, state = IDLE, internal counters = 0. Reset overrides everything, including mid-sweep; no partial pulses after the reset edge.
- States: IDLE, START, RUN.
- IDLE:
  - Outputs 0 except sweep_count, which holds its value.
  - enable sampled high at edge k -> START from edge k; start and busy are high in the cycle after edge k.
- START:
  - start=1, channel=0, channel_index=0.
  - Lasts exactly START_WIDTH_CLK clocks, then RUN.
- RUN:
  - Slot counter runs 0..CHANNEL_PERIOD_CLK-1.
  - channel=1 while slot counter < PULSE_WIDTH_CLK, otherwise 0.
  - When slot counter == CHANNEL_PERIOD_CLK-1:
    - Not the last slot: channel_index increments.
    - Last slot (channel_index == CHANNEL_NUMBER-1): sweep_done=1 and sweep_count increments in the same cycle. Next state is START if enable=1, else IDLE. channel_index returns to 0.
- Sweep length: START_WIDTH_CLK + CHANNEL_NUMBER*CHANNEL_PERIOD_CLK clocks, with no idle gap between back-to-back sweeps.
- enable deasserted mid-sweep: the sweep completes in full (see optional feature).
- enable toggling within one sweep has no effect; enable is only sampled in IDLE and on the last clock of a sweep.
- sweep_count wraps from all-ones to 0 without any other side effect.

Optional Feature:
- Macro: MESSBAUER_CHANNEL_SEQUENCER_ABORT_EN.
- Defined: enable sampled low in START or RUN forces IDLE on that edge.
  - start, channel, channel_index and busy are 0 in the following cycle.
  - sweep_done does not fire and sweep_count does not increment.
- Undefined: enable low only takes effect at the end of the current sweep, as described in Behaviour.

Test Plan (CHANNEL_NUMBER=4, CHANNEL_INDEX_WIDTH=2, CHANNEL_PERIOD_CLK=5, PULSE_WIDTH_CLK=2, START_WIDTH_CLK=3):
- Reset: hold rst high 3 clocks with enable=1 -> all outputs 0; after release, start high for exactly 3 clocks, then busy.
- Single sweep: enable pulsed high 1 clock in IDLE ->
  - start high 3 clocks;
  - 4 channel pulses, each high 2 clocks and low 3;
  - channel_index steps 0,1,2,3;
  - sweep_done on clock 23 of the sweep; sweep_count=1; then IDLE, busy=0.
- Continuous: enable held high for 3 sweeps -> sweep_count=3, 3 sweep_done strobes 23 clocks apart, start reasserted with no gap.
- Reset mid-sweep: rst asserted at channel_index=2 while channel=1 -> next cycle all outputs 0, state IDLE, sweep_count=0.
- Enable drop: enable low at channel_index=1.
  - Macro undefined: sweep finishes, sweep_count=1, then IDLE.
  - Macro defined: IDLE next clock, sweep_count=0, no sweep_done.
- Wrap: SWEEP_COUNT_WIDTH=2, run 5 sweeps -> sweep_count sequence 1,2,3,0,1.
